// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg
// Shared definitions for the RAM access arbiter:
//   - ADDR_W_DEF / DATA_W_DEF : default RAM address and data widths
//   - op_t                    : SPI-side command opcodes (a_cmd[DATA_W+1:DATA_W])
//   - state_t                 : arbiter FSM state encoding
//   - op_is_load()            : true for the address-load opcodes (00/10)
package spi_ram_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        OP_LD_WR = 2'b00,   // load write address from payload
        OP_WRITE = 2'b01,   // write payload to write address
        OP_LD_RD = 2'b10,   // load read address from payload
        OP_READ  = 2'b11    // read from read address, payload ignored
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RDATA  = 2'b10
    } state_t;

    // Address loads are the opcodes with bit 0 clear.
    function automatic logic op_is_load(input op_t op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter with a last-served register.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   en             : grant is being taken this cycle; updates last-served
//   req_a, req_b   : requests
//   gnt_a, gnt_b   : combinational one-hot grant
// After reset last-served is B, so A wins the first tie.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    logic last_b;

    // A wins when alone, or on a tie when B was served last.
    always_comb begin
        gnt_a = req_a && (!req_b || last_b);
        gnt_b = req_b && !gnt_a;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_b <= 1'b1;
        end else if (en && (gnt_a || gnt_b)) begin
            last_b <= gnt_b;
        end
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
// Shares one single-port RAM (1-cycle read latency) between an SPI-side
// command stream (A) and a local host request port (B).
// Ports:
//   clk, rst_n                     : clock, synchronous active-low reset
//   a_cmd, a_valid                 : SPI command word {opcode, payload} + strobe
//   a_rdata, a_rvalid              : SPI read return, one-cycle strobe
//   b_req, b_we, b_addr, b_wdata   : host request (b_req is a level)
//   b_gnt                          : one-cycle accept; request fields captured then
//   b_rdata, b_rvalid              : host read return, one-cycle strobe
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata           : RAM interface
//   err_ovf                        : sticky flag, SPI command dropped on full slot
//   fsm_state                      : current FSM state (observability)
// Handshake: A is fire-and-forget; a_valid is a single-cycle strobe captured
// into a one-deep slot. B holds b_req high until b_gnt is seen high at a
// clock edge; that edge is the transfer.
// Build option: define RAM_ARB_AUTO_INC_EN to post-increment wr_addr after
// each write command and rd_addr after each read command (wrapping).
module ram_access_arbiter
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W+1:0] a_cmd,
    input  logic              a_valid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_ovf,
    output state_t            fsm_state
);

`ifdef RAM_ARB_AUTO_INC_EN
    localparam logic AUTO_INC = 1'b1;
`else
    localparam logic AUTO_INC = 1'b0;
`endif

    state_t            state;
    logic              slot_full;
    logic [DATA_W+1:0] slot_cmd;
    op_t               slot_op;
    logic [DATA_W-1:0] slot_payload;
    logic [ADDR_W-1:0] payload_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              owner_b;
    logic              is_read;

    logic in_idle;
    logic load_now;
    logic req_a;
    logic req_b;
    logic gnt_a;
    logic gnt_b;
    logic grant_a;
    logic grant_b;
    logic consume;

    assign slot_op      = op_t'(slot_cmd[DATA_W+1:DATA_W]);
    assign slot_payload = slot_cmd[DATA_W-1:0];
    assign payload_addr = ADDR_W'(slot_payload);

    assign in_idle  = (state == ST_IDLE);
    // A pending address load is handled on its own in IDLE: it blocks B for
    // that cycle and does not touch the round-robin history.
    assign load_now = in_idle && slot_full && op_is_load(slot_op);
    assign req_a    = slot_full && !op_is_load(slot_op);
    assign req_b    = b_req && !load_now;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_idle),
        .req_a (req_a),
        .req_b (req_b),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    assign grant_a   = in_idle && gnt_a;
    assign grant_b   = in_idle && gnt_b;
    assign b_gnt     = grant_b;
    assign consume   = load_now || grant_a;
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            slot_full <= 1'b0;
            slot_cmd  <= '0;
            wr_addr   <= '0;
            rd_addr   <= '0;
            err_ovf   <= 1'b0;
            owner_b   <= 1'b0;
            is_read   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            a_rdata   <= '0;
            a_rvalid  <= 1'b0;
            b_rdata   <= '0;
            b_rvalid  <= 1'b0;
        end else begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;

            // Slot: a strobe arriving in the cycle the slot drains is kept.
            if (a_valid) begin
                if (!slot_full || consume) begin
                    slot_cmd  <= a_cmd;
                    slot_full <= 1'b1;
                end else begin
                    err_ovf <= 1'b1;
                end
            end else if (consume) begin
                slot_full <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (load_now) begin
                        if (slot_op == OP_LD_WR) begin
                            wr_addr <= payload_addr;
                        end else begin
                            rd_addr <= payload_addr;
                        end
                    end else if (grant_a) begin
                        state   <= ST_ACCESS;
                        mem_en  <= 1'b1;
                        owner_b <= 1'b0;
                        if (slot_op == OP_WRITE) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= wr_addr;
                            mem_wdata <= slot_payload;
                            is_read   <= 1'b0;
                            if (AUTO_INC) begin
                                wr_addr <= wr_addr + ADDR_W'(1);
                            end
                        end else begin
                            mem_addr <= rd_addr;
                            is_read  <= 1'b1;
                            if (AUTO_INC) begin
                                rd_addr <= rd_addr + ADDR_W'(1);
                            end
                        end
                    end else if (grant_b) begin
                        state     <= ST_ACCESS;
                        mem_en    <= 1'b1;
                        mem_we    <= b_we;
                        mem_addr  <= b_addr;
                        mem_wdata <= b_wdata;
                        is_read   <= !b_we;
                        owner_b   <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    state <= is_read ? ST_RDATA : ST_IDLE;
                end
                ST_RDATA: begin
                    // RAM data is valid this cycle; return it to the owner.
                    state <= ST_IDLE;
                    if (owner_b) begin
                        b_rdata  <= mem_rdata;
                        b_rvalid <= 1'b1;
                    end else begin
                        a_rdata  <= mem_rdata;
                        a_rvalid <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter
// Directed scenarios followed by randomized traffic against a behavioural
// model (address registers + shadow memory + expected read queue).
// Honours RAM_ARB_AUTO_INC_EN in the same way as the design build.
module tb_ram_access_arbiter;
  import spi_ram_pkg::*;

`ifdef RAM_ARB_AUTO_INC_EN
  localparam logic [7:0] INC = 8'd1;
`else
  localparam logic [7:0] INC = 8'd0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] a_cmd;
  logic       a_valid;
  logic [7:0] a_rdata;
  logic       a_rvalid;
  logic       b_req, b_we;
  logic [7:0] b_addr, b_wdata;
  logic       b_gnt;
  logic [7:0] b_rdata;
  logic       b_rvalid;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       err_ovf;
  state_t     fsm_state;

  always #5 clk = ~clk;

  ram_access_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_cmd(a_cmd), .a_valid(a_valid), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .err_ovf(err_ovf), .fsm_state(fsm_state)
  );

  // RAM environment: single port, 1-cycle read latency.
  logic [7:0] ram [256];
  logic       ram_clr;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // ---------------- scoreboard / model ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_ram [256];
  logic [7:0] m_wr, m_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_send(input op_t op, input logic [7:0] pl);
    step();
    a_cmd   = {op, pl};
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    repeat (4) step();
  endtask

  // Issue an A read and compare against the head of exp_q.
  task automatic a_read();
    logic       got;
    logic [7:0] e;
    got = 1'b0;
    step();
    a_cmd   = {OP_READ, 8'($urandom)};
    a_valid = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      a_valid = 1'b0;
      @(negedge clk);
      if (a_rvalid) got = 1'b1;
    end
    chk("a_rvalid_seen", {31'd0, got}, 32'd1);
    e = exp_q.pop_front();
    if (got) chk("a_rdata", {24'd0, a_rdata}, {24'd0, e});
    repeat (2) step();
  endtask

  task automatic b_op(input logic we, input logic [7:0] addr, input logic [7:0] data);
    logic       got;
    logic [7:0] e;
    got = 1'b0;
    step();
    b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = data;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (b_gnt) got = 1'b1;
      step();
    end
    b_req = 1'b0;
    chk("b_gnt_seen", {31'd0, got}, 32'd1);
    if (!we) begin
      e   = exp_q.pop_front();
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
        @(negedge clk);
        if (b_rvalid) got = 1'b1;
        else step();
      end
      chk("b_rvalid_seen", {31'd0, got}, 32'd1);
      if (got) chk("b_rdata", {24'd0, b_rdata}, {24'd0, e});
    end
    repeat (3) step();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [7:0] d, a;
    int         kind;
    rst_n = 1'b0; ram_clr = 1'b1;
    a_cmd = '0; a_valid = 1'b0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    step(); step();
    ram_clr = 1'b0;
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_state",    32'(fsm_state), 32'(ST_IDLE));
    chk("rst_err_ovf",  {31'd0, err_ovf},  32'd0);
    chk("rst_mem_en",   {31'd0, mem_en},   32'd0);
    chk("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    chk("rst_b_gnt",    {31'd0, b_gnt},    32'd0);

    // Contention: A write pending and B write in the same IDLE cycle
    step(); a_cmd = {OP_WRITE, 8'h77}; a_valid = 1'b1;
    step(); a_valid = 1'b0; b_req = 1'b1; b_we = 1'b1; b_addr = 8'h20; b_wdata = 8'h55;
    @(negedge clk);
    chk("tie_b_gnt_lost", {31'd0, b_gnt}, 32'd0);
    step();
    @(negedge clk);
    chk("tie_a_mem_en",  {31'd0, mem_en}, 32'd1);
    chk("tie_a_mem_we",  {31'd0, mem_we}, 32'd1);
    chk("tie_a_addr",    {24'd0, mem_addr},  32'h00);
    chk("tie_a_wdata",   {24'd0, mem_wdata}, 32'h77);
    chk("tie_b_gnt_busy", {31'd0, b_gnt}, 32'd0);
    step();
    @(negedge clk);
    chk("tie_b_gnt_next", {31'd0, b_gnt}, 32'd1);
    step(); b_req = 1'b0;
    @(negedge clk);
    chk("tie_b_mem_en", {31'd0, mem_en}, 32'd1);
    chk("tie_b_addr",   {24'd0, mem_addr},  32'h20);
    chk("tie_b_wdata",  {24'd0, mem_wdata}, 32'h55);
    repeat (2) step();
    chk("tie_ram0",  {24'd0, ram[8'h00]}, 32'h77);
    chk("tie_ram20", {24'd0, ram[8'h20]}, 32'h55);

    // Overflow: two strobes while busy with a B read
    step(); b_req = 1'b1; b_we = 1'b0; b_addr = 8'h20;
    @(negedge clk);
    chk("ovf_b_gnt", {31'd0, b_gnt}, 32'd1);
    step(); b_req = 1'b0; a_cmd = {OP_LD_WR, 8'h30}; a_valid = 1'b1;
    step(); a_cmd = {OP_LD_WR, 8'h40};
    @(negedge clk);
    chk("ovf_not_yet", {31'd0, err_ovf}, 32'd0);
    step(); a_valid = 1'b0;
    @(negedge clk);
    chk("ovf_b_rvalid", {31'd0, b_rvalid}, 32'd1);
    chk("ovf_b_rdata",  {24'd0, b_rdata},  32'h55);
    chk("ovf_set",      {31'd0, err_ovf},  32'd1);
    a_send(OP_WRITE, 8'h99);
    chk("ovf_kept_first", {24'd0, ram[8'h30]}, 32'h99);
    repeat (10) step();
    chk("ovf_sticky", {31'd0, err_ovf}, 32'd1);

    // Write then read back through A, with exact latency
    a_send(OP_LD_WR, 8'h10);
    a_send(OP_WRITE, 8'hAB);
    a_send(OP_LD_RD, 8'h10);
    step(); a_cmd = {OP_READ, 8'h5A}; a_valid = 1'b1;
    step(); a_valid = 1'b0;
    @(negedge clk);
    chk("rd_c1_mem_en", {31'd0, mem_en}, 32'd0);
    step();
    @(negedge clk);
    chk("rd_c2_mem_en", {31'd0, mem_en}, 32'd1);
    chk("rd_c2_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rd_c2_addr",   {24'd0, mem_addr}, 32'h10);
    step();
    @(negedge clk);
    chk("rd_c3_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("rd_c3_mem_en", {31'd0, mem_en}, 32'd0);
    step();
    @(negedge clk);
    chk("rd_c4_rvalid", {31'd0, a_rvalid}, 32'd1);
    chk("rd_c4_rdata",  {24'd0, a_rdata},  32'hAB);
    step();
    @(negedge clk);
    chk("rd_c5_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("rd_c5_hold",   {24'd0, a_rdata},  32'hAB);
    chk("rd_ram10",     {24'd0, ram[8'h10]}, 32'hAB);

    // Address wrap with/without auto-increment
    a_send(OP_LD_WR, 8'hFF);
    a_send(OP_WRITE, 8'h11);
    a_send(OP_WRITE, 8'h22);
    chk("wrap_ramff", {24'd0, ram[8'hFF]}, (INC != 0) ? 32'h11 : 32'h22);
    chk("wrap_ram00", {24'd0, ram[8'h00]}, (INC != 0) ? 32'h22 : 32'h77);

    // Reset during RDATA of a B read
    step(); b_req = 1'b1; b_we = 1'b0; b_addr = 8'h10;
    @(negedge clk);
    chk("rstrd_b_gnt", {31'd0, b_gnt}, 32'd1);
    step(); b_req = 1'b0;
    step(); rst_n = 1'b0;
    @(negedge clk);
    chk("rstrd_in_rdata", 32'(fsm_state), 32'(ST_RDATA));
    step();
    @(negedge clk);
    chk("rstrd_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    chk("rstrd_state",    32'(fsm_state), 32'(ST_IDLE));
    chk("rstrd_outs", {b_rdata, a_rdata, mem_addr, mem_wdata}, 32'd0);
    chk("rstrd_flags", {27'd0, mem_en, mem_we, a_rvalid, err_ovf, b_gnt}, 32'd0);
    step(); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstrd_no_rvalid", {31'd0, b_rvalid}, 32'd0);
      step();
    end
    a_send(OP_LD_RD, 8'h10);
    exp_q.push_back(8'hAB);
    a_read();

    // Randomized traffic in region 0x40..0x4F
    m_wr = 8'h00;
    m_rd = 8'h10 + INC;
    for (int i = 0; i < 16; i++) begin
      a = 8'h40 + 8'(i);
      d = 8'($urandom);
      exp_ram[a] = d;
      b_op(1'b1, a, d);
    end
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3);
      a = 8'h40 + 8'($urandom_range(0, 15));
      d = 8'($urandom);
      case (kind)
        0: begin
          if (m_wr < 8'h40 || m_wr > 8'h4F || $urandom_range(0, 1) == 1) begin
            a_send(OP_LD_WR, a);
            m_wr = a;
          end
          a_send(OP_WRITE, d);
          exp_ram[m_wr] = d;
          m_wr = m_wr + INC;
        end
        1: begin
          if (m_rd < 8'h40 || m_rd > 8'h4F || $urandom_range(0, 1) == 1) begin
            a_send(OP_LD_RD, a);
            m_rd = a;
          end
          exp_q.push_back(exp_ram[m_rd]);
          a_read();
          m_rd = m_rd + INC;
        end
        2: begin
          exp_ram[a] = d;
          b_op(1'b1, a, d);
        end
        default: begin
          exp_q.push_back(exp_ram[a]);
          b_op(1'b0, a, d);
        end
      endcase
    end
    chk("final_err_ovf", {31'd0, err_ovf}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
